// File: rtl/axi_rr_burst_arbiter.sv
// axi_rr_burst_arbiter: round-robin arbiter with burst lock
// for one shared AXI channel (AR, AW or W).
module axi_rr_burst_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             locked_o
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] lock_q;
  logic [IDX_W-1:0] lock_d;
  logic [IDX_W-1:0] scan_idx;
  logic             scan_hit;
  logic [IDX_W-1:0] win;
  logic             vld;
  logic             hs;

  function automatic logic [IDX_W-1:0] next_idx(
    input logic [IDX_W-1:0] i
  );
    if (i == IDX_W'(N_REQ - 1)) return '0;
    return i + IDX_W'(1);
  endfunction

  // First asserted request at or after ptr_q,
  // wrapping modulo N_REQ rather than 2^IDX_W.
  always_comb begin
    logic [IDX_W:0] cand;
    scan_hit = 1'b0;
    scan_idx = ptr_q;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ))
        cand = cand - (IDX_W+1)'(N_REQ);
      if (!scan_hit && req_i[cand[IDX_W-1:0]]) begin
        scan_hit = 1'b1;
        scan_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    win     = scan_idx;
    vld     = scan_hit;
    unique case (state_q)
      IDLE: begin
        if (vld && ready_i) begin
          if (last_i[win]) begin
            ptr_d = next_idx(win);
          end else begin
            lock_d  = win;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        win = lock_q;
        vld = req_i[lock_q];
        if (vld && ready_i && last_i[lock_q]) begin
          state_d = IDLE;
          ptr_d   = next_idx(lock_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign hs = vld & ready_i;

  // Reset forces every output low regardless of inputs.
  always_comb begin
    valid_o   = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    locked_o  = 1'b0;
    if (!rst) begin
      valid_o   = vld;
      gnt_idx_o = win;
      locked_o  = (state_q == LOCKED);
      for (int i = 0; i < N_REQ; i++)
        gnt_o[i] = hs && (win == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

endmodule

// File: tb/tb_axi_rr_burst_arbiter.sv
// tb_axi_rr_burst_arbiter: directed bench for the
// round-robin burst arbiter (N_REQ=4 and N_REQ=3).
module tb_axi_rr_burst_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] last;
  logic       ready;
  logic       valid;
  logic [3:0] gnt;
  logic [1:0] idx;
  logic       locked;

  logic [2:0] req3;
  logic [2:0] last3;
  logic       ready3;
  logic       valid3;
  logic [2:0] gnt3;
  logic [1:0] idx3;
  logic       locked3;

  int total;
  int bad;

  axi_rr_burst_arbiter #(.N_REQ(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .last_i   (last),
    .ready_i  (ready),
    .valid_o  (valid),
    .gnt_o    (gnt),
    .gnt_idx_o(idx),
    .locked_o (locked)
  );

  axi_rr_burst_arbiter #(.N_REQ(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req3),
    .last_i   (last3),
    .ready_i  (ready3),
    .valid_o  (valid3),
    .gnt_o    (gnt3),
    .gnt_idx_o(idx3),
    .locked_o (locked3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vectors are {valid, gnt, idx, locked}.
  task automatic test_reset();
    logic [7:0] e4;
    logic [6:0] e3;
    @(negedge clk);
    rst = 1; req = 4'b1111; last = 4'b1111; ready = 1;
    req3 = 3'b111; last3 = 3'b111; ready3 = 1;
    #1;
    e4 = 8'b0;
    e3 = 7'b0;
    total++;
    if ({valid, gnt, idx, locked} !== e4) begin
      bad++;
      $display("FAIL reset4: got %b want %b",
               {valid, gnt, idx, locked}, e4);
    end
    total++;
    if ({valid3, gnt3, idx3, locked3} !== e3) begin
      bad++;
      $display("FAIL reset3: got %b want %b",
               {valid3, gnt3, idx3, locked3}, e3);
    end
    @(negedge clk);
    rst = 0; req = 0; last = 0; req3 = 0; last3 = 0;
    #1;
    total++;
    if ({valid, gnt, idx, locked} !== e4) begin
      bad++;
      $display("FAIL post_reset4: got %b want %b",
               {valid, gnt, idx, locked}, e4);
    end
    total++;
    if ({valid3, gnt3, idx3, locked3} !== e3) begin
      bad++;
      $display("FAIL post_reset3: got %b want %b",
               {valid3, gnt3, idx3, locked3}, e3);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] e4;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req = 4'b1111; last = 4'b1111; ready = 1;
      #1;
      e4 = {1'b1, 4'(1 << (k % 4)), 2'(k % 4), 1'b0};
      total++;
      if ({valid, gnt, idx, locked} !== e4) begin
        bad++;
        $display("FAIL rr[%0d]: got %b want %b",
                 k, {valid, gnt, idx, locked}, e4);
      end
    end
    @(negedge clk);
    req = 0; last = 0;
    #1;
    e4 = 8'b0_0000_00_0;
    total++;
    if ({valid, gnt, idx, locked} !== e4) begin
      bad++;
      $display("FAIL rr_ptr: got %b want %b",
               {valid, gnt, idx, locked}, e4);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] rv [4];
    logic [7:0] ev [4];
    rv = '{4'b0100, 4'b0000, 4'b0101, 4'b0000};
    ev = '{8'b1_0100_10_0, 8'b0_0000_11_0,
           8'b1_0001_00_0, 8'b0_0000_01_0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req = rv[k]; last = 4'b1111; ready = 1;
      #1;
      total++;
      if ({valid, gnt, idx, locked} !== ev[k]) begin
        bad++;
        $display("FAIL wrap[%0d]: got %b want %b",
                 k, {valid, gnt, idx, locked}, ev[k]);
      end
    end
  endtask

  task automatic test_burst();
    logic       rdy [7];
    logic [3:0] lv  [7];
    logic [7:0] ev  [7];
    rdy = '{1, 0, 1, 1, 0, 1, 1};
    lv  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
            4'b0010, 4'b0010, 4'b1111};
    ev  = '{8'b1_0010_01_0, 8'b1_0000_01_1,
            8'b1_0010_01_1, 8'b1_0010_01_1,
            8'b1_0000_01_1, 8'b1_0010_01_1,
            8'b1_0100_10_0};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      req = 4'b1111; last = lv[k]; ready = rdy[k];
      #1;
      total++;
      if ({valid, gnt, idx, locked} !== ev[k]) begin
        bad++;
        $display("FAIL burst[%0d]: got %b want %b",
                 k, {valid, gnt, idx, locked}, ev[k]);
      end
    end
  endtask

  task automatic test_drop();
    logic [3:0] rv [7];
    logic [3:0] lv [7];
    logic [7:0] ev [7];
    rv = '{4'b1111, 4'b0111, 4'b0111, 4'b0111,
           4'b1111, 4'b1111, 4'b1111};
    lv = '{4'b0000, 4'b1111, 4'b1111, 4'b1111,
           4'b0000, 4'b1000, 4'b1111};
    ev = '{8'b1_1000_11_0, 8'b0_0000_11_1,
           8'b0_0000_11_1, 8'b0_0000_11_1,
           8'b1_1000_11_1, 8'b1_1000_11_1,
           8'b1_0001_00_0};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      req = rv[k]; last = lv[k]; ready = 1;
      #1;
      total++;
      if ({valid, gnt, idx, locked} !== ev[k]) begin
        bad++;
        $display("FAIL drop[%0d]: got %b want %b",
                 k, {valid, gnt, idx, locked}, ev[k]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic       rs [5];
    logic [3:0] rv [5];
    logic [3:0] lv [5];
    logic       rd [5];
    logic [7:0] ev [5];
    rs = '{0, 0, 1, 0, 0};
    rv = '{4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0000};
    lv = '{4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0000};
    rd = '{1, 0, 1, 1, 1};
    ev = '{8'b1_0100_10_0, 8'b1_0000_10_1,
           8'b0_0000_00_0, 8'b1_0010_01_0,
           8'b0_0000_10_0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rst = rs[k]; req = rv[k]; last = lv[k]; ready = rd[k];
      #1;
      total++;
      if ({valid, gnt, idx, locked} !== ev[k]) begin
        bad++;
        $display("FAIL rst_mid[%0d]: got %b want %b",
                 k, {valid, gnt, idx, locked}, ev[k]);
      end
    end
  endtask

  task automatic test_back_to_back_n3();
    logic [6:0] e3;
    logic [2:0] rv [5];
    logic [6:0] ev [5];
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req3 = 3'b111; last3 = 3'b111; ready3 = 1;
      #1;
      e3 = {1'b1, 3'(1 << (k % 3)), 2'(k % 3), 1'b0};
      total++;
      if ({valid3, gnt3, idx3, locked3} !== e3) begin
        bad++;
        $display("FAIL n3_rr[%0d]: got %b want %b",
                 k, {valid3, gnt3, idx3, locked3}, e3);
      end
    end
    rv = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000};
    ev = '{7'b0_000_00_0, 7'b1_100_10_0, 7'b0_000_00_0,
           7'b1_010_01_0, 7'b0_000_10_0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req3 = rv[k]; last3 = 3'b111; ready3 = 1;
      #1;
      total++;
      if ({valid3, gnt3, idx3, locked3} !== ev[k]) begin
        bad++;
        $display("FAIL n3_wrap[%0d]: got %b want %b",
                 k, {valid3, gnt3, idx3, locked3}, ev[k]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1; req = 0; last = 0; ready = 0;
    req3 = 0; last3 = 0; ready3 = 0;
    repeat (2) @(posedge clk);
    test_reset();
    test_round_robin();
    test_wrap();
    test_burst();
    test_drop();
    test_reset_mid_burst();
    test_back_to_back_n3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rr_burst_arbiter.md
Name: axi_rr_burst_arbiter

Overview:
- N-way round-robin arbiter with burst lock for one shared AXI channel (AR, AW or W) inside the node arbitration trees.
- Selects one requester per transfer. Holds the selection until the winner's last beat is handshaken. Then rotates priority to the index after the winner.
- Replaces free-running flag counters with winner-relative rotation, so idle requesters never cost a slot.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- IDX_W, $clog2(N_REQ), width of the index and pointer fields.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req_i  input  N_REQ  per-requester valid. Once high, it must stay high until granted.
- last_i  input  N_REQ  per-requester last-beat marker; qualified by req_i.
- ready_i  input  1  downstream ready of the shared channel.
- valid_o  output  1  downstream valid; equals req_i of the current winner.
- gnt_o  output  N_REQ  one-hot per-requester ready: gnt_o[w] = ready_i for winner w, all other bits 0.
- gnt_idx_o  output  IDX_W  index of the current winner; drives the datapath mux select.
- locked_o  output  1  high while in LOCKED state.

Behaviour:
- State register: state_q ∈ {IDLE, LOCKED}. Reset value: IDLE.
- Priority pointer: ptr_q [IDX_W-1:0]. Reset value: 0. This index has highest priority in IDLE.
- Lock register: lock_q [IDX_W-1:0]. Reset value: 0.
- Handshake: hs = valid_o & ready_i.

IDLE:
- Winner w is the first asserted req_i bit scanning ptr_q, ptr_q+1, ..., N_REQ-1, 0, ..., ptr_q-1. The search is combinational and has zero latency: grant appears the same cycle as the request.
- If no req_i bit is set: valid_o=0, gnt_o=0, gnt_idx_o=ptr_q.
- hs & last_i[w]: ptr_q <= (w==N_REQ-1) ? 0 : w+1; stay in IDLE. A single-beat transfer never locks.
- hs & !last_i[w]: lock_q <= w; state -> LOCKED; ptr_q unchanged.
- No hs: no state change. The winner may change next cycle only if a higher-priority request appears. AXI stability is guaranteed because a requester with req_i high keeps it high.

LOCKED:
- Winner is lock_q, regardless of the other req_i bits.
- valid_o = req_i[lock_q]; gnt_idx_o = lock_q; locked_o = 1.
- hs & last_i[lock_q]: state -> IDLE; ptr_q <= lock_q+1, wrapping to 0 after N_REQ-1.
- Otherwise hold. If the winner drops req_i mid-burst, stay locked and wait; no timeout.

Reset and output rules:
- While rst=1, next-cycle state is IDLE, ptr_q=0, lock_q=0.
- While rst=1, outputs are forced: valid_o=0, gnt_o=0, locked_o=0, gnt_idx_o=0, independent of inputs.
- Reset mid-burst abandons the lock. The upstream slave reset is handled elsewhere.

Invariants and arithmetic:
- Pointer arithmetic is modulo N_REQ, not modulo 2^IDX_W. For non-power-of-two N_REQ, ptr_q never exceeds N_REQ-1.
- gnt_o is always one-hot or zero.
- A requester waiting in IDLE is granted within N_REQ-1 completed bursts of the others.
- Same-cycle req deassert by others while LOCKED has no effect.

Test Plan:
- Reset then all req_i=4'b1111, last_i=4'b1111, ready_i=1 for 8 cycles -> gnt_idx_o sequence 0,1,2,3,0,1,2,3; gnt_o one-hot matching; locked_o stays 0.
- ptr_q=0, req_i=4'b0100 single-beat then req_i=4'b0101 -> grants 2, then 0 (wrap). ptr_q goes 3 then 1.
- Requester 1 sends a 4-beat burst (last on beat 4), req_i=4'b1111 throughout, ready_i toggling 1,0,1,1,0,1 -> gnt_idx_o=1 and locked_o=1 until the 4th handshake. Next grant is index 2.
- LOCKED on index 3, winner drops req_i for 3 cycles mid-burst while others request -> valid_o=0, gnt_o=0, gnt_idx_o stays 3. Resumes on index 3 and completes before any other grant.
- N_REQ=3, back-to-back single beats from all three -> ptr_q cycles 1,2,0 and never reaches 3.
- Assert rst for 1 cycle while LOCKED on index 2 -> next cycle state IDLE, ptr_q=0. With req_i=4'b0110, grant goes to index 1.
